// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures an asynchronous step/pulse train: the rise-to-rise period and
//   the high time within that period, both in clk cycles. It also keeps a
//   running count of rising edges and flags a train that has stopped.
//
// Parameters
//   WIDTH    width of every count/measurement output
//   TIMEOUT  clocks without a rising edge before the train counts as stalled
//            (2 <= TIMEOUT < 2^WIDTH-1)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   enable      measurement enable; low idles the meter and holds outputs
//   count_clr   synchronous clear of edge_count
//   pulse_in    asynchronous pulse train
//   period      last measured rise-to-rise period
//   high_time   high time belonging to that period (0 if no fall was seen)
//   edge_count  rising edges seen while active, wraps modulo 2^WIDTH
//   valid       one-cycle strobe when period/high_time update
//   stalled     level, set after TIMEOUT clocks without a rising edge
module pulse_period_meter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 100000000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             count_clr,
    input  logic             pulse_in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] high_time,
    output logic [WIDTH-1:0] edge_count,
    output logic             valid,
    output logic             stalled
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_EDGE,
        MEASURE
    } state_t;

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);

    state_t           state;
    logic             sync1;
    logic             pulse_s;
    logic             pulse_d;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] hshadow;
    logic             rise;
    logic             fall;
    logic             count_edge;

    assign rise       = pulse_s & ~pulse_d;
    assign fall       = ~pulse_s & pulse_d;
    assign count_edge = rise && enable && (state != IDLE);

    // Synchronizer and edge history run independently of enable, so a level
    // that is already high when the meter is enabled is never seen as an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1   <= 1'b0;
            pulse_s <= 1'b0;
            pulse_d <= 1'b0;
        end else begin
            sync1   <= pulse_in;
            pulse_s <= sync1;
            pulse_d <= pulse_s;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_count <= '0;
        end else if (count_clr) begin
            // an edge arriving with the clear is kept as the first count
            edge_count <= count_edge ? ONE : '0;
        end else if (count_edge) begin
            edge_count <= edge_count + ONE;
        end
    end

    // cnt holds k in the k-th cycle after the reference rise, so on the next
    // rise it equals the period and on a fall it equals the high time.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hshadow   <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            stalled   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (!enable) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: state <= WAIT_EDGE;
                    WAIT_EDGE: begin
                        // first edge only establishes the reference
                        if (rise) begin
                            state   <= MEASURE;
                            cnt     <= ONE;
                            hshadow <= '0;
                        end
                    end
                    MEASURE: begin
                        if (rise) begin
                            // a rise landing on the timeout cycle still captures
                            period    <= cnt;
                            high_time <= hshadow;
                            valid     <= 1'b1;
                            stalled   <= 1'b0;
                            cnt       <= ONE;
                            hshadow   <= '0;
                        end else if (cnt == TIMEOUT_W) begin
                            stalled   <= 1'b1;
                            period    <= '0;
                            high_time <= '0;
                            cnt       <= '0;
                            state     <= WAIT_EDGE;
                        end else begin
                            // cnt < TIMEOUT here, so the count saturates by
                            // leaving MEASURE rather than by clamping
                            if (fall) hshadow <= cnt;
                            cnt <= cnt + ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: two instances (8-bit/TIMEOUT 50 and
// 4-bit/TIMEOUT 12) share one directed stimulus. A timestamp model predicts
// every output each cycle; literal checks pin the model at key points.
module tb_pulse_period_meter;

    localparam int TO_A = 50;
    localparam int TO_B = 12;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       count_clr = 1'b0;
    logic       pulse_in = 1'b0;
    logic [7:0] pa, ha, ea;
    logic [3:0] pb, hb, eb;
    logic       va, sa, vb, sb;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned vcount = 0;

    pulse_period_meter #(.WIDTH(8), .TIMEOUT(TO_A)) ua (
        .clk(clk), .reset(reset), .enable(enable), .count_clr(count_clr),
        .pulse_in(pulse_in), .period(pa), .high_time(ha), .edge_count(ea),
        .valid(va), .stalled(sa));

    pulse_period_meter #(.WIDTH(4), .TIMEOUT(TO_B)) ub (
        .clk(clk), .reset(reset), .enable(enable), .count_clr(count_clr),
        .pulse_in(pulse_in), .period(pb), .high_time(hb), .edge_count(eb),
        .valid(vb), .stalled(sb));

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A rise of the synchronized input is acted on at edge n when the input
    // sampled two edges earlier was high and three edges earlier was low.
    // Periods and high times are differences of edge timestamps.
    bit     started = 1'b0;
    bit     hist[4];
    bit     m_on[2], m_armed[2], e_valid[2], e_stall[2];
    longint t_ref[2], t_fall[2], e_per[2], e_high[2], e_cnt[2];
    longint cyc = 0;
    longint to_v[2] = '{TO_A, TO_B};
    longint wrap[2] = '{256, 16};

    always @(posedge clk) begin : model
        bit rise, fall, rst_s, en_s, clr_s, counted;
        rst_s = reset;
        en_s  = enable;
        clr_s = count_clr;
        cyc++;
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pulse_in;
        if (rst_s) begin
            hist[0] = 1'b0;
            hist[1] = 1'b0;
            hist[2] = 1'b0;
        end
        rise = hist[2] & ~hist[3];
        fall = ~hist[2] & hist[3];
        for (int i = 0; i < 2; i++) begin
            e_valid[i] = 1'b0;
            if (rst_s) begin
                m_on[i] = 0; m_armed[i] = 0; e_stall[i] = 0;
                e_per[i] = 0; e_high[i] = 0; e_cnt[i] = 0;
            end else begin
                counted = m_on[i] && en_s && rise;
                if (counted) e_cnt[i] = (e_cnt[i] + 1) % wrap[i];
                if (clr_s) e_cnt[i] = counted ? 1 : 0;
                if (!en_s) begin
                    m_on[i] = 0; m_armed[i] = 0;
                end else if (!m_on[i]) begin
                    m_on[i] = 1; m_armed[i] = 0;
                end else if (!m_armed[i]) begin
                    if (rise) begin m_armed[i] = 1; t_ref[i] = cyc; t_fall[i] = -1; end
                end else if (rise) begin
                    e_per[i]   = cyc - t_ref[i];
                    e_high[i]  = (t_fall[i] < 0) ? 0 : t_fall[i] - t_ref[i];
                    e_valid[i] = 1; e_stall[i] = 0;
                    t_ref[i] = cyc; t_fall[i] = -1;
                end else if (cyc - t_ref[i] == to_v[i]) begin
                    e_stall[i] = 1; e_per[i] = 0; e_high[i] = 0; m_armed[i] = 0;
                end else if (fall) begin
                    t_fall[i] = cyc;
                end
            end
        end
        if (rst_s) started = 1'b1;
        #1;
        if (started) begin
            chk("a_valid", va, e_valid[0]);
            chk("a_period", pa, e_per[0]);
            chk("a_high", ha, e_high[0]);
            chk("a_edges", ea, e_cnt[0]);
            chk("a_stalled", sa, e_stall[0]);
            chk("b_valid", vb, e_valid[1]);
            chk("b_period", pb, e_per[1]);
            chk("b_high", hb, e_high[1]);
            chk("b_edges", eb, e_cnt[1]);
            chk("b_stalled", sb, e_stall[1]);
            if (va) vcount++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic train(input int per, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            pulse_in = 1'b1;
            repeat (hi) @(negedge clk);
            pulse_in = 1'b0;
            repeat (per - hi) @(negedge clk);
        end
    endtask

    initial begin
        // reset with the input toggling
        repeat (3) begin
            @(negedge clk);
            pulse_in = ~pulse_in;
        end
        chk("lit_rst_period", pa, 0);
        chk("lit_rst_high", ha, 0);
        chk("lit_rst_edges", ea, 0);
        chk("lit_rst_valid", va, 0);
        chk("lit_rst_stalled", sa, 0);
        reset = 1'b0;
        pulse_in = 1'b0;
        train(2, 1, 3);
        chk("lit_dis_edges", ea, 0);
        chk("lit_dis_period", pa, 0);

        // steady train 10/5
        enable = 1'b1;
        repeat (3) @(negedge clk);
        vcount = 0;
        train(10, 5, 6);
        chk("lit_steady_period", pa, 10);
        chk("lit_steady_high", ha, 5);
        chk("lit_steady_edges", ea, 6);
        chk("lit_steady_valids", vcount, 5);

        // frequency change to 7/3
        train(7, 3, 3);
        chk("lit_chg_period", pa, 7);
        chk("lit_chg_high", ha, 3);
        chk("lit_chg_edges", ea, 9);

        // train stops -> stall
        repeat (60) @(negedge clk);
        chk("lit_stall_a", sa, 1);
        chk("lit_stall_period", pa, 0);
        chk("lit_stall_high", ha, 0);
        chk("lit_stall_b", sb, 1);

        // resume at period 20
        vcount = 0;
        train(20, 10, 1);
        chk("lit_resume1_stalled", sa, 1);
        chk("lit_resume1_valids", vcount, 0);
        train(20, 10, 1);
        chk("lit_resume2_stalled", sa, 0);
        chk("lit_resume2_period", pa, 20);
        chk("lit_resume2_high", ha, 10);
        chk("lit_resume2_valids", vcount, 1);
        chk("lit_resume2_edges", ea, 11);

        // disable mid-period, re-enable while the input is high
        train(10, 5, 3);
        chk("lit_pre_dis_edges", ea, 14);
        enable = 1'b0;
        vcount = 0;
        pulse_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("lit_dis_hold_period", pa, 10);
        chk("lit_dis_hold_high", ha, 5);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        pulse_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("lit_reen_edges", ea, 14);
        chk("lit_reen_valids", vcount, 0);
        train(10, 5, 2);
        chk("lit_reen2_valids", vcount, 1);
        chk("lit_reen2_edges", ea, 16);
        chk("lit_reen2_period", pa, 10);

        // reset mid-period
        pulse_in = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        pulse_in = 1'b0;
        @(negedge clk);
        chk("lit_midrst_period", pa, 0);
        chk("lit_midrst_edges", ea, 0);
        chk("lit_midrst_stalled", sa, 0);
        chk("lit_midrst_b_edges", eb, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // edge counter wrap on the 4-bit instance
        train(4, 2, 15);
        chk("lit_wrap15_b", eb, 15);
        chk("lit_wrap15_a", ea, 15);
        chk("lit_p4_period", pa, 4);
        train(4, 2, 1);
        chk("lit_wrap0_b", eb, 0);
        chk("lit_wrap16_a", ea, 16);

        // clear coincident with a counted rise
        pulse_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        chk("lit_clr_rise_a", ea, 1);
        chk("lit_clr_rise_b", eb, 1);
        pulse_in = 1'b0;
        repeat (2) @(negedge clk);

        // minimum period 2 (1 high, 1 low)
        train(2, 1, 4);
        repeat (3) @(negedge clk);
        chk("lit_p2_period_a", pa, 2);
        chk("lit_p2_high_a", ha, 1);
        chk("lit_p2_period_b", pb, 2);
        chk("lit_p2_high_b", hb, 1);

        // clear alone
        count_clr = 1'b1;
        @(negedge clk);
        count_clr = 1'b0;
        chk("lit_clr_a", ea, 0);
        chk("lit_clr_b", eb, 0);

        // rise on the same cycle as the 4-bit instance's timeout
        train(12, 6, 3);
        chk("lit_to_rise_period_b", pb, 12);
        chk("lit_to_rise_high_b", hb, 6);
        chk("lit_to_rise_stalled_b", sb, 0);
        chk("lit_to_rise_period_a", pa, 12);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
